// File: rtl/sw_conditioner.sv
// Debounces a bank of toggle switches: 2-flop synchronizer, shared sample-tick prescaler,
// and a per-bit STABLE_N-sample agreement window that drives sw_clean plus edge pulses.
module sw_conditioner #(
  parameter int WIDTH    = 18,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_N = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic             tick
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int HIST_W = STABLE_N - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [WIDTH-1:0]  r_sync1;
  logic [WIDTH-1:0]  r_sync2;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_tick;
  logic [HIST_W-1:0] r_hist [WIDTH];
  logic [WIDTH-1:0]  r_clean;
  logic [WIDTH-1:0]  r_rise;
  logic [WIDTH-1:0]  r_fall;

  logic [HIST_W-1:0] w_hist_nxt [WIDTH];
  logic [WIDTH-1:0]  w_all1;
  logic [WIDTH-1:0]  w_all0;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_fall;

  // Window is {hist, sync2}; the cast drops the oldest sample when shifting in the new one.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_all1[i]     = (&r_hist[i]) & r_sync2[i];
      w_all0[i]     = ~(|r_hist[i]) & ~r_sync2[i];
      w_hist_nxt[i] = HIST_W'({r_hist[i], r_sync2[i]});
    end
    w_rise = w_all1 & ~r_clean;
    w_fall = w_all0 & r_clean;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_clean <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      r_sync1 <= SW;
      r_sync2 <= r_sync1;
      r_tick  <= (r_cnt == CNT_MAX);
      r_cnt   <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
      r_rise  <= '0;
      r_fall  <= '0;
      if (r_tick) begin
        for (int i = 0; i < WIDTH; i++) begin
          r_hist[i] <= w_hist_nxt[i];
        end
        r_clean <= (r_clean | w_rise) & ~w_fall;
        r_rise  <= w_rise;
        r_fall  <= w_fall;
      end
    end
  end

  assign sw_clean   = r_clean;
  assign sw_rise    = r_rise;
  assign sw_fall    = r_fall;
  assign sw_changed = |(r_rise | r_fall);
  assign tick       = r_tick;

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner with TICK_DIV=4, STABLE_N=3, WIDTH=18.
module tb_sw_conditioner;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic [W-1:0] clean, rise, fall;
  logic         changed, tick;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rise_acc, fall_acc;
  int chg_cycles, dup_cnt, overlap_cnt, coinc_cnt;

  sw_conditioner #(.WIDTH(W), .TICK_DIV(4), .STABLE_N(3)) dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .SW        (sw),
    .sw_clean  (clean),
    .sw_rise   (rise),
    .sw_fall   (fall),
    .sw_changed(changed),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sw;
    int           hold;
    logic [W-1:0] exp_clean;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
    int           exp_chg;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    rise_acc = '0; fall_acc = '0;
    chg_cycles = 0; dup_cnt = 0; overlap_cnt = 0; coinc_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if ((rise_acc & rise) != '0 || (fall_acc & fall) != '0) dup_cnt++;
    rise_acc |= rise;
    fall_acc |= fall;
    if (changed) chg_cycles++;
    if ((rise & fall) != '0) overlap_cnt++;
    if (changed !== |(rise | fall)) coinc_cnt++;
  endtask

  initial begin
    int tick_bad, tick_cnt, lat;
    vecs[0] = '{18'h00000, 20, 18'h00000, 18'h00000, 18'h00000, 0};
    vecs[1] = '{18'h00001, 20, 18'h00001, 18'h00001, 18'h00000, 1};
    vecs[2] = '{18'h00009,  2, 18'h00001, 18'h00000, 18'h00000, 0};
    vecs[3] = '{18'h00001, 20, 18'h00001, 18'h00000, 18'h00000, 0};
    vecs[4] = '{18'h3FFFF, 20, 18'h3FFFF, 18'h3FFFE, 18'h00000, 1};
    vecs[5] = '{18'h00000, 20, 18'h00000, 18'h00000, 18'h3FFFF, 1};
    vecs[6] = '{18'h0002A, 20, 18'h0002A, 18'h0002A, 18'h00000, 1};
    vecs[7] = '{18'h00015, 20, 18'h00015, 18'h00015, 18'h0002A, 1};
    vecs[8] = '{18'h00000,  2, 18'h00015, 18'h00000, 18'h00000, 0};
    vecs[9] = '{18'h00015, 20, 18'h00015, 18'h00000, 18'h00000, 0};

    rst = 1'b1;
    sw  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_clean", 32'(clean), 0);
    chk("reset_pulses", 32'(rise | fall), 0);
    chk("reset_tick", 32'(tick), 0);
    rst = 1'b0;

    // Idle with SW=0: tick must land on every 4th cycle after release, no output activity.
    clr_mon();
    tick_bad = 0;
    tick_cnt = 0;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (tick) tick_cnt++;
      if (tick !== (c % 4 == 0)) tick_bad++;
    end
    chk("idle_tick_phase", 32'(tick_bad), 0);
    chk("idle_tick_count", 32'(tick_cnt), 12);
    chk("idle_clean", 32'(clean), 0);
    chk("idle_pulses", 32'(rise_acc | fall_acc), 0);

    for (int v = 0; v < 10; v++) begin
      clr_mon();
      sw = vecs[v].sw;
      for (int c = 0; c < vecs[v].hold; c++) step();
      chk($sformatf("v%0d_clean", v), 32'(clean), 32'(vecs[v].exp_clean));
      chk($sformatf("v%0d_rise", v), 32'(rise_acc), 32'(vecs[v].exp_rise));
      chk($sformatf("v%0d_fall", v), 32'(fall_acc), 32'(vecs[v].exp_fall));
      chk($sformatf("v%0d_chg_cycles", v), 32'(chg_cycles), 32'(vecs[v].exp_chg));
      chk($sformatf("v%0d_dup", v), 32'(dup_cnt + overlap_cnt + coinc_cnt), 0);
    end

    // SW[1] bounces with a 6-cycle period, which never gives 3 equal samples 4 cycles apart.
    clr_mon();
    for (int c = 0; c < 40; c++) begin
      sw[1] = ((c / 3) % 2) == 0;
      step();
    end
    chk("bounce_clean", 32'(clean), 32'h15);
    chk("bounce_pulses", 32'(rise_acc | fall_acc), 0);
    clr_mon();
    sw[1] = 1'b1;
    lat = 0;
    while (!clean[1] && lat < 16) begin
      step();
      lat++;
    end
    chk("bounce_hold_within_15", 32'(lat <= 15), 1);
    repeat (10) step();
    chk("bounce_hold_clean", 32'(clean), 32'h17);
    chk("bounce_hold_rise", 32'(rise_acc), 32'h2);
    chk("bounce_hold_chg", 32'(chg_cycles), 1);
    chk("bounce_hold_dup", 32'(dup_cnt + overlap_cnt + coinc_cnt), 0);

    // Reset in the middle of accepting SW[2]; acceptance restarts from an empty window.
    sw = '0;
    repeat (20) step();
    chk("pre_rst_clean", 32'(clean), 0);
    clr_mon();
    sw = 18'h00004;
    repeat (6) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("midrst_clean", 32'(clean), 0);
    chk("midrst_pulses", 32'(rise_acc | fall_acc), 0);
    lat = 0;
    while (!clean[2] && lat < 16) begin
      step();
      lat++;
    end
    chk("midrst_lat_within_15", 32'(lat <= 15), 1);
    chk("midrst_lat_min", 32'(lat >= 8), 1);
    repeat (10) step();
    chk("midrst_clean_after", 32'(clean), 32'h4);
    chk("midrst_rise", 32'(rise_acc), 32'h4);
    chk("midrst_chg", 32'(chg_cycles), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
